alu_op_sequencer: RTL and testbench

Parametrised, clocked successor to the combinational ALU control decoder of the multicycle processor. Decodes ALUOp/funct into a registered ALU opcode, gives SLT its own opcode, flags illegal encodings, and adds an iterative unsigned shift-add multiplier for `mult`. It sits between the main control FSM and the ALU. A start/busy/done handshake lets the control FSM stall for the duration of multi-cycle operations.

---
 rtl/alu_op_sequencer_pkg.sv | 60 ++++++
 rtl/alu_op_sequencer_if.sv | 31 +++
 rtl/alu_op_sequencer_mult_iter.sv | 50 +++++
 rtl/alu_op_sequencer.sv | 107 ++++++++++
 tb/tb_alu_op_sequencer.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/alu_op_sequencer_pkg.sv
// Shared constants, opcode decode and FSM state type for the ALU op sequencer.
// Imported by alu_op_sequencer, mult_iter and the bench.
package alu_seq_pkg;

  localparam logic [2:0] ALUOP_RTYPE  = 3'b000;
  localparam logic [2:0] ALUOP_BRANCH = 3'b001;
  localparam logic [2:0] ALUOP_ADDI   = 3'b010;
  localparam logic [2:0] ALUOP_ANDI   = 3'b011;
  localparam logic [2:0] ALUOP_ORI    = 3'b100;
  localparam logic [2:0] ALUOP_ADDIE  = 3'b111;

  localparam logic [5:0] FUNCT_ADD  = 6'b100000;
  localparam logic [5:0] FUNCT_SUB  = 6'b100010;
  localparam logic [5:0] FUNCT_MULT = 6'b100100;
  localparam logic [5:0] FUNCT_AND  = 6'b111000;
  localparam logic [5:0] FUNCT_OR   = 6'b111001;
  localparam logic [5:0] FUNCT_SLT  = 6'b111100;

  localparam logic [3:0] OPC_ADD     = 4'b0000;
  localparam logic [3:0] OPC_SUB     = 4'b0001;
  localparam logic [3:0] OPC_MULT    = 4'b0010;
  localparam logic [3:0] OPC_AND     = 4'b0011;
  localparam logic [3:0] OPC_OR      = 4'b0100;
  localparam logic [3:0] OPC_SLT     = 4'b0101;
  localparam logic [3:0] OPC_ILLEGAL = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } seq_state_e;

  // mult_en = 0 folds funct 100100 into the illegal class.
  function automatic logic [3:0] decode_op(input logic [2:0] aluop,
                                           input logic [5:0] funct,
                                           input logic       mult_en);
    logic [3:0] opc;
    opc = OPC_ILLEGAL;
    case (aluop)
      ALUOP_RTYPE: begin
        case (funct)
          FUNCT_ADD:  opc = OPC_ADD;
          FUNCT_SUB:  opc = OPC_SUB;
          FUNCT_MULT: opc = mult_en ? OPC_MULT : OPC_ILLEGAL;
          FUNCT_AND:  opc = OPC_AND;
          FUNCT_OR:   opc = OPC_OR;
          FUNCT_SLT:  opc = OPC_SLT;
          default:    opc = OPC_ILLEGAL;
        endcase
      end
      ALUOP_ADDI, ALUOP_ADDIE: opc = OPC_ADD;
      ALUOP_ANDI:              opc = OPC_AND;
      ALUOP_ORI:               opc = OPC_OR;
      ALUOP_BRANCH:            opc = OPC_SUB;
      default:                 opc = OPC_ILLEGAL;
    endcase
    return opc;
  endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Request/response bundle between the main control FSM (master) and the
// ALU op sequencer (slave).
interface alu_op_sequencer_if #(
  parameter int W   = 32,
  parameter int OPW = 4
);
  // start is a one-cycle request, taken only while busy is low; start while
  // busy (including the done cycle) is dropped. done pulses once per accepted
  // request, illegal coincides with done, busy is high from acceptance to done.
  logic           start;
  logic [2:0]     ALUOp;
  logic [5:0]     funct;
  logic [W-1:0]   op_a;
  logic [W-1:0]   op_b;
  logic [OPW-1:0] ALUopcode;
  logic [W-1:0]   prod_hi;
  logic [W-1:0]   prod_lo;
  logic           busy;
  logic           done;
  logic           illegal;

  modport master (
    output start, ALUOp, funct, op_a, op_b,
    input  ALUopcode, prod_hi, prod_lo, busy, done, illegal
  );

  modport slave (
    input  start, ALUOp, funct, op_a, op_b,
    output ALUopcode, prod_hi, prod_lo, busy, done, illegal
  );
endinterface

// File: rtl/alu_op_sequencer_mult_iter.sv
// Iterative unsigned shift-add multiplier: one partial-product step per cycle,
// W steps per product. nxt_* are the accumulator values after the current step.
module mult_iter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         step,
  input  logic [W-1:0] mcand_in,
  input  logic [W-1:0] mplier_in,
  output logic         last,
  output logic [W-1:0] nxt_hi,
  output logic [W-1:0] nxt_lo
);
  localparam int CW = $clog2(W + 1);

  logic [W-1:0]  mcand;
  logic [W-1:0]  acc_hi;
  logic [W-1:0]  acc_lo;
  logic [CW-1:0] count;
  logic [W:0]    sum;

  // acc_lo starts as the multiplier and fills with product bits as it shifts.
  always_comb begin
    sum    = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mcand} : '0);
    nxt_hi = sum[W:1];
    nxt_lo = {sum[0], acc_lo[W-1:1]};
  end

  assign last = (count == CW'(W - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand  <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      count  <= '0;
    end else if (load) begin
      mcand  <= mcand_in;
      acc_hi <= '0;
      acc_lo <= mplier_in;
      count  <= '0;
    end else if (step) begin
      acc_hi <= nxt_hi;
      acc_lo <= nxt_lo;
      count  <= count + 1'b1;
    end
  end
endmodule

// File: rtl/alu_op_sequencer.sv
// Clocked ALU control decoder with start/busy/done handshake. Define
// ALU_SEQ_MULT_EN to include the iterative multiplier behind funct 100100.
import alu_seq_pkg::*;

module alu_op_sequencer #(
  parameter int W   = 32,
  parameter int OPW = 4
) (
  input  logic                clk,
  input  logic                rst,
  alu_op_sequencer_if.slave   bus,
  output seq_state_e          state_dbg
);
  seq_state_e state;
  logic [3:0] dec_opc;

`ifdef ALU_SEQ_MULT_EN
  localparam logic MULT_EN = 1'b1;
`else
  localparam logic MULT_EN = 1'b0;
`endif

  assign dec_opc   = decode_op(bus.ALUOp, bus.funct, MULT_EN);
  assign state_dbg = state;

`ifdef ALU_SEQ_MULT_EN
  logic         mul_load;
  logic         mul_step;
  logic         mul_last;
  logic [W-1:0] mul_hi;
  logic [W-1:0] mul_lo;

  assign mul_load = (state == ST_IDLE) && bus.start && (dec_opc == OPC_MULT);
  assign mul_step = (state == ST_MUL);

  mult_iter #(.W(W)) u_mult_iter (
    .clk       (clk),
    .rst       (rst),
    .load      (mul_load),
    .step      (mul_step),
    .mcand_in  (bus.op_a),
    .mplier_in (bus.op_b),
    .last      (mul_last),
    .nxt_hi    (mul_hi),
    .nxt_lo    (mul_lo)
  );
`else
  logic unused_ops;
  assign unused_ops  = ^{bus.op_a, bus.op_b};
  assign bus.prod_hi = '0;
  assign bus.prod_lo = '0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      bus.ALUopcode <= '0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.illegal   <= 1'b0;
`ifdef ALU_SEQ_MULT_EN
      bus.prod_hi   <= '0;
      bus.prod_lo   <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            bus.ALUopcode <= OPW'(dec_opc);
            bus.busy      <= 1'b1;
`ifdef ALU_SEQ_MULT_EN
            if (dec_opc == OPC_MULT) begin
              state <= ST_MUL;
            end else begin
              state       <= ST_DONE;
              bus.done    <= 1'b1;
              bus.illegal <= (dec_opc == OPC_ILLEGAL);
            end
`else
            state       <= ST_DONE;
            bus.done    <= 1'b1;
            bus.illegal <= (dec_opc == OPC_ILLEGAL);
`endif
          end
        end
`ifdef ALU_SEQ_MULT_EN
        // The final step's result is captured directly, so prod_* and done rise together.
        ST_MUL: begin
          if (mul_last) begin
            state       <= ST_DONE;
            bus.done    <= 1'b1;
            bus.prod_hi <= mul_hi;
            bus.prod_lo <= mul_lo;
          end
        end
`endif
        ST_DONE: begin
          state       <= ST_IDLE;
          bus.busy    <= 1'b0;
          bus.done    <= 1'b0;
          bus.illegal <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed plus randomized bench for alu_op_sequencer against a table-driven
// reference model; follows ALU_SEQ_MULT_EN the same way the design does.
module tb_alu_op_sequencer;
  import alu_seq_pkg::*;

  localparam int W   = 32;
  localparam int OPW = 4;

`ifdef ALU_SEQ_MULT_EN
  localparam bit MULT_ON = 1'b1;
`else
  localparam bit MULT_ON = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_op_sequencer_if #(.W(W), .OPW(OPW)) bus ();
  seq_state_e state_dbg;

  alu_op_sequencer #(.W(W), .OPW(OPW)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // scoreboard
  logic [W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  // reference model: opcode tables and the last completed product
  logic [3:0]     class_opc [8] = '{4'hF, 4'h1, 4'h0, 4'h3, 4'h4, 4'hF, 4'hF, 4'h0};
  logic [5:0]     rt_funct  [6] = '{6'h20, 6'h22, 6'h24, 6'h38, 6'h39, 6'h3C};
  logic [3:0]     rt_opc    [6] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5};
  logic [2*W-1:0] m_prod;

  function automatic logic [3:0] ref_opcode(input logic [2:0] aluop, input logic [5:0] f);
    logic [3:0] r;
    r = class_opc[aluop];
    if (aluop == 3'd0) begin
      r = 4'hF;
      for (int i = 0; i < 6; i++)
        if (rt_funct[i] == f) r = rt_opc[i];
      if (r == 4'h2 && !MULT_ON) r = 4'hF;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "/opcode"},  W'(bus.ALUopcode), '0);
    chk({tag, "/prod_hi"}, bus.prod_hi, '0);
    chk({tag, "/prod_lo"}, bus.prod_lo, '0);
    chk({tag, "/busy"},    W'(bus.busy), '0);
    chk({tag, "/done"},    W'(bus.done), '0);
    chk({tag, "/illegal"}, W'(bus.illegal), '0);
    chk({tag, "/state"},   W'(state_dbg), W'(ST_IDLE));
  endtask

  // driver: entered on a negedge with the DUT idle, returns on a negedge with it idle
  task automatic run_req(input logic [2:0] aluop, input logic [5:0] f,
                         input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit poke, input string tag);
    logic [3:0]     eo;
    logic [2*W-1:0] a64, b64;
    logic [W-1:0]   e;
    int             exp_lat;
    int             lat;
    eo = ref_opcode(aluop, f);
    exp_lat = 1;
    if (eo == 4'h2) begin
      a64 = {{W{1'b0}}, a};
      b64 = {{W{1'b0}}, b};
      m_prod = a64 * b64;
      exp_lat = W + 1;
    end
    exp_q.push_back(W'(eo));
    exp_q.push_back(W'(eo == 4'hF));
    exp_q.push_back(m_prod[2*W-1:W]);
    exp_q.push_back(m_prod[W-1:0]);

    bus.ALUOp = aluop; bus.funct = f; bus.op_a = a; bus.op_b = b; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk({tag, "/opc_early"}, W'(bus.ALUopcode), W'(eo));
    chk({tag, "/busy_early"}, W'(bus.busy), 1);
    lat = 1;
    while (bus.done !== 1'b1 && lat < W + 10) begin
      if (poke && lat == 5) begin
        bus.ALUOp = ALUOP_ORI; bus.op_a = 3; bus.op_b = 5; bus.start = 1'b1;
      end
      @(negedge clk);
      bus.start = 1'b0;
      lat++;
    end
    chk({tag, "/latency"}, W'(lat), W'(exp_lat));
    e = exp_q.pop_front(); chk({tag, "/opcode"},  W'(bus.ALUopcode), e);
    e = exp_q.pop_front(); chk({tag, "/illegal"}, W'(bus.illegal), e);
    e = exp_q.pop_front(); chk({tag, "/prod_hi"}, bus.prod_hi, e);
    e = exp_q.pop_front(); chk({tag, "/prod_lo"}, bus.prod_lo, e);
    chk({tag, "/busy_done"}, W'(bus.busy), 1);
    if (poke) begin
      bus.ALUOp = ALUOP_ORI; bus.start = 1'b1;
    end
    @(negedge clk);
    bus.start = 1'b0;
    chk({tag, "/done_pulse"}, W'(bus.done), 0);
    chk({tag, "/busy_end"}, W'(bus.busy), 0);
    if (poke) chk({tag, "/opc_hold"}, W'(bus.ALUopcode), W'(eo));
  endtask

  initial begin
    logic [2:0] ra;
    logic [5:0] rf;
    rst = 1'b1;
    bus.start = 1'b0; bus.ALUOp = '0; bus.funct = '0; bus.op_a = '0; bus.op_b = '0;
    m_prod = '0;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b0;
    @(negedge clk);

    run_req(3'b000, 6'b100010, 0, 0, 1'b0, "sub");
    run_req(3'b000, 6'b111100, 0, 0, 1'b0, "slt");
    for (int k = 1; k < 8; k++)
      run_req(3'(k), 6'($urandom_range(0, 63)), 1, 2, 1'b0, "class");
    for (int k = 0; k < 6; k++)
      run_req(3'b000, rt_funct[k], W'(k + 3), W'(k + 11), 1'b0, "rtype");

    run_req(3'b000, 6'b100100, 7, 6, 1'b0, "mul7x6");
    run_req(3'b000, 6'b100100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, "mulmax");
    run_req(3'b101, 6'b100000, 0, 0, 1'b0, "ill_class");
    run_req(3'b000, 6'b000111, 0, 0, 1'b0, "ill_funct");

    // reset while a multiply (or, without the multiplier, an illegal op) is under way
    run_req(3'b001, 6'd0, 0, 0, 1'b0, "pre_rst");
    bus.ALUOp = 3'b000; bus.funct = 6'b100100; bus.op_a = 5; bus.op_b = 9; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset_vals("rst_mid");
    m_prod = '0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_req(3'b010, 6'd0, 0, 0, 1'b0, "post_rst_add");

    for (int k = 0; k < 40; k++) begin
      ra = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1) rf = rt_funct[$urandom_range(0, 5)];
      else rf = 6'($urandom_range(0, 63));
      run_req(ra, rf, $urandom, $urandom, 1'($urandom_range(0, 1)), "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
